// File: rtl/rx_frame_loader.sv
// Loads one image frame from a UART byte stream into frame memory,
// then hands it to the downsampling processor.
module rx_frame_loader #(
    parameter int IMG_BYTES      = 65536,
    parameter int ADDR_WIDTH     = 16,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            rx_byte,
    input  logic                  rx_done,
    input  logic                  proc_done,
    output logic                  mem_wr_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [7:0]            mem_wdata,
    output logic                  proc_start,
    output logic                  busy,
    output logic                  load_error,
    output logic                  overrun
);

    localparam int CW = ADDR_WIDTH + 1;
    localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(IMG_BYTES - 1);
    localparam logic [TW-1:0] IDLE_MAX = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        PROC,
        ERR
    } state_t;

    state_t        state;
    logic [CW-1:0] count;
    logic [TW-1:0] idle_cnt;
    logic          rx_done_q;
    logic          start_pend;
    logic          nb;

    assign nb = rx_done & ~rx_done_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            count      <= '0;
            idle_cnt   <= '0;
            rx_done_q  <= 1'b1;
            start_pend <= 1'b0;
            mem_wr_en  <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            proc_start <= 1'b0;
            busy       <= 1'b0;
            load_error <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            rx_done_q  <= rx_done;
            mem_wr_en  <= 1'b0;
            start_pend <= 1'b0;
            proc_start <= start_pend;

            if (nb || state != LOAD)
                idle_cnt <= '0;
            else
                idle_cnt <= idle_cnt + 1'b1;

            unique case (state)
                IDLE, ERR: begin
                    if (nb) begin
                        mem_wr_en  <= 1'b1;
                        mem_addr   <= '0;
                        mem_wdata  <= rx_byte;
                        count      <= CW'(1);
                        state      <= LOAD;
                        busy       <= 1'b1;
                        load_error <= 1'b0;
                    end
                end
                LOAD: begin
                    if (nb) begin
                        mem_wr_en <= 1'b1;
                        mem_addr  <= count[ADDR_WIDTH-1:0];
                        mem_wdata <= rx_byte;
                        count     <= count + 1'b1;
                        if (count == LAST_CNT) begin
                            state      <= PROC;
                            start_pend <= 1'b1;
                        end
                    end else if (idle_cnt == IDLE_MAX) begin
                        // a byte on the timeout cycle wins, handled above
                        state      <= ERR;
                        count      <= '0;
                        busy       <= 1'b0;
                        load_error <= 1'b1;
                    end
                end
                PROC: begin
                    if (nb)
                        overrun <= 1'b1;
                    if (proc_done) begin
                        state <= IDLE;
                        count <= '0;
                        busy  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
